// File: rtl/lsu_pkg.sv
// Shared types, constants and lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_width_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        FIN
    } lsu_state_e;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;
    localparam int unsigned LSU_CNT_W           = 16;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            LSU_B, LSU_H, LSU_W: ok = 1'b1;
            LSU_BU, LSU_HU:      ok = !is_store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

    // Byte offset actually used on the bus: bits below the access width are dropped.
    function automatic logic [1:0] lane_offset(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [1:0] off;
        case (funct3[1:0])
            2'b00:   off = addr_lo;
            2'b01:   off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            LSU_B:   rd_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  rd_data = {24'b0, byte_sel};
            LSU_H:   rd_data = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  rd_data = {16'b0, half_sel};
            default: rd_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction per accepted start.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of truncating.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [LSU_CNT_W-1:0] CNT_LAST = LSU_CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e           state;
    logic [LSU_CNT_W-1:0] cnt;
    logic                 store_q;
    logic [2:0]           funct3_q;
    logic [1:0]           off_q;

    logic [1:0]  off_eff;
    logic        bad_access;
    logic [31:0] load_fmt;

    assign off_eff = lane_offset(funct3, addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_access = !funct3_legal(is_store, funct3) || is_misaligned(funct3, addr[1:0]);
`else
    assign bad_access = !funct3_legal(is_store, funct3);
`endif

    lsu_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .funct3    (funct3_q),
        .addr_lo   (off_q),
        .rd_data   (load_fmt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            store_q   <= 1'b0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        store_q  <= is_store;
                        funct3_q <= funct3;
                        off_q    <= off_eff;
                        busy     <= 1'b1;
                        if (bad_access) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= lane_be(funct3, off_eff);
                            mem_wdata <= lane_wdata(funct3, wdata);
                        end
                    end
                end
                REQ: begin
                    // A grant on the last allowed cycle still wins over the timeout.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (store_q) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= RESP;
                            cnt   <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        state   <= FIN;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        rd_data <= load_fmt;
                        state   <= FIN;
                        done    <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios and randomized accesses checked against a behavioural model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu;

    localparam int TO      = 4;
    localparam int MAX_CYC = 40;

    logic        clk, rst_n, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rd_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int          total, bad;
    logic [31:0] exp_rd;

    int          o_req_cycles, o_busy_cycles, o_done_cnt, o_done_cyc;
    logic        o_we, o_err, o_busy_after, o_req_unstable;
    logic [31:0] o_addr, o_wdata, o_rd;
    logic [3:0]  o_be;

    int          e_req, e_done;
    logic        e_err, e_load_ok;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_data    (rd_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = m_size(f3);
        return (int'(a[1:0]) / sz) * sz;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int          sz;
        logic [31:0] v, mask;
        sz = m_size(f3);
        if (sz == 4) return rd;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = (rd >> (8 * m_off(f3, a))) & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_legal(input logic st, input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
        if (!st && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (int'(a[1:0]) % m_size(f3)) != 0;
`else
        return (f3 == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input int gdly, input int rdly);
        e_load_ok = 1'b0;
        if (!m_legal(st, f3) || m_trap(f3, a)) begin
            e_req = 0; e_done = 1; e_err = 1'b1;
        end else if (gdly >= TO) begin
            e_req = TO; e_done = TO + 1; e_err = 1'b1;
        end else if (st) begin
            e_req = gdly + 1; e_done = gdly + 2; e_err = 1'b0;
        end else if (rdly >= TO) begin
            e_req = gdly + 1; e_done = gdly + 2 + TO; e_err = 1'b1;
        end else begin
            e_req = gdly + 1; e_done = gdly + rdly + 3; e_err = 1'b0; e_load_ok = 1'b1;
        end
    endtask

    // ---------------- bus driver / observer ----------------
    // Entered just after a falling edge with the DUT idle; returns one falling edge after done.
    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int gdly, input int rdly,
                              input logic [31:0] rdat);
        int req_wait, resp_wait, phase;
        bit seen_done;
        o_req_cycles = 0; o_busy_cycles = 0; o_done_cnt = 0; o_done_cyc = -1;
        o_we = 1'b0; o_err = 1'b0; o_req_unstable = 1'b0; o_rd = 'x;
        o_addr = '0; o_wdata = '0; o_be = '0;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_gnt = 1'b0;
        phase = 0; req_wait = 0; resp_wait = 0; seen_done = 0;
        for (int cyc = 1; cyc <= MAX_CYC && !seen_done; cyc++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (o_req_cycles == 0) begin
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata ||
                             mem_we !== o_we) begin
                    o_req_unstable = 1'b1;
                end
                o_req_cycles++;
            end
            if (busy === 1'b1) o_busy_cycles++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            start = 1'($urandom_range(0, 1));
            if (done === 1'b1) begin
                o_done_cnt++; o_done_cyc = cyc; o_err = err; o_rd = rd_data; seen_done = 1;
                mem_rvalid = 1'b1;
            end else if (phase == 0 && mem_req === 1'b1) begin
                if (req_wait == gdly) begin
                    mem_gnt = 1'b1; mem_rvalid = 1'b1;
                    phase = st ? 2 : 1;
                end else begin
                    req_wait++;
                end
            end else if (phase == 1) begin
                if (resp_wait == rdly) begin
                    mem_rvalid = 1'b1; mem_rdata = rdat; phase = 2;
                end else begin
                    resp_wait++;
                end
            end
        end
        @(negedge clk);
        o_busy_after = busy;
        if (done === 1'b1) o_done_cnt++;
        start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin bad++;
            $display("FAIL reset_ctrl got=%b want=00000", {busy, done, err, mem_req, mem_we}); end
        total++; if (rd_data !== 32'h0) begin bad++;
            $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        total++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin bad++;
            $display("FAIL reset_bus got=%h/%h/%h want=0", mem_addr, mem_be, mem_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        run_access(1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0, 32'h0);
        total++; if (o_addr !== 32'h1000_0004) begin bad++;
            $display("FAIL sw_addr got=%h want=10000004", o_addr); end
        total++; if (o_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b want=1111", o_be); end
        total++; if (o_wdata !== 32'hDEAD_BEEF || o_we !== 1'b1) begin bad++;
            $display("FAIL sw_wdata got=%h we=%b want=deadbeef we=1", o_wdata, o_we); end
        total++; if (o_done_cyc !== 2 || o_err !== 1'b0) begin bad++;
            $display("FAIL sw_done got=%0d err=%b want=2 err=0", o_done_cyc, o_err); end
        run_access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0);
        total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b want=1000", o_be); end
        total++; if (o_wdata !== 32'hA5A5_A5A5) begin bad++;
            $display("FAIL sb_wdata got=%h want=a5a5a5a5", o_wdata); end
        total++; if (o_addr !== 32'h0000_0100) begin bad++;
            $display("FAIL sb_addr got=%h want=00000100", o_addr); end
    endtask

    task automatic test_load();
        run_access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 0, 32'h80FF_7F01);
        total++; if (o_rd !== 32'hFFFF_FF80) begin bad++;
            $display("FAIL lb_data got=%h want=ffffff80", o_rd); end
        total++; if (o_done_cyc !== 3 || o_we !== 1'b0 || o_be !== 4'b1000) begin bad++;
            $display("FAIL lb_bus got=cyc%0d we=%b be=%b want=cyc3 we=0 be=1000",
                     o_done_cyc, o_we, o_be); end
        run_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 0, 32'h80FF_7F01);
        total++; if (o_rd !== 32'h0000_0080) begin bad++;
            $display("FAIL lbu_data got=%h want=00000080", o_rd); end
        run_access(1'b0, 3'b001, 32'h0000_0200, 32'h0, 0, 0, 32'h80FF_7F01);
        total++; if (o_rd !== 32'h0000_7F01 || o_be !== 4'b0011) begin bad++;
            $display("FAIL lh_data got=%h be=%b want=00007f01 be=0011", o_rd, o_be); end
        exp_rd = 32'h0000_7F01;
    endtask

    task automatic test_delayed();
        logic [31:0] r;
        r = $urandom | 32'h1;
        run_access(1'b0, 3'b010, 32'h0000_0A0C, 32'h0, 3, 2, r);
        total++; if (o_req_cycles !== 4 || o_req_unstable !== 1'b0) begin bad++;
            $display("FAIL dly_req got=%0d unstable=%b want=4 unstable=0",
                     o_req_cycles, o_req_unstable); end
        total++; if (o_done_cyc !== 8 || o_busy_cycles !== 8 || o_busy_after !== 1'b0) begin bad++;
            $display("FAIL dly_busy got=done%0d busy%0d after=%b want=done8 busy8 after=0",
                     o_done_cyc, o_busy_cycles, o_busy_after); end
        total++; if (o_done_cnt !== 1 || o_rd !== r) begin bad++;
            $display("FAIL dly_data got=%0d/%h want=1/%h", o_done_cnt, o_rd, r); end
        exp_rd = r;
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h0000_0800, 32'h0, 0, 99, 32'h1234_5678);
        total++; if (o_err !== 1'b1 || o_done_cyc !== 2 + TO || o_done_cnt !== 1) begin bad++;
            $display("FAIL timeout_done got=err%b cyc%0d n%0d want=err1 cyc%0d n1",
                     o_err, o_done_cyc, o_done_cnt, 2 + TO); end
        total++; if (o_rd !== exp_rd) begin bad++;
            $display("FAIL timeout_rd got=%h want=%h", o_rd, exp_rd); end
        repeat (2) begin
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = ~exp_rd;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++; if (rd_data !== exp_rd || busy !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL late_rvalid got=%h busy=%b done=%b want=%h 0 0",
                     rd_data, busy, done, exp_rd); end
    endtask

    task automatic test_misalign();
        run_access(1'b0, 3'b001, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_8765);
`ifdef LSU_MISALIGN_TRAP_EN
        total++; if (o_err !== 1'b1 || o_req_cycles !== 0 || o_done_cyc !== 1) begin bad++;
            $display("FAIL misalign_trap got=err%b req%0d cyc%0d want=err1 req0 cyc1",
                     o_err, o_req_cycles, o_done_cyc); end
        total++; if (o_rd !== exp_rd) begin bad++;
            $display("FAIL misalign_rd got=%h want=%h", o_rd, exp_rd); end
`else
        total++; if (o_err !== 1'b0 || o_be !== 4'b0011 || o_addr !== 32'h0000_2000) begin bad++;
            $display("FAIL misalign_bus got=err%b be%b %h want=err0 be0011 00002000",
                     o_err, o_be, o_addr); end
        total++; if (o_rd !== 32'hFFFF_8765) begin bad++;
            $display("FAIL misalign_rd got=%h want=ffff8765", o_rd); end
        exp_rd = 32'hFFFF_8765;
`endif
    endtask

    task automatic test_illegal();
        run_access(1'b0, 3'b011, 32'h0000_0040, 32'h0, 0, 0, 32'h5555_5555);
        total++; if (o_err !== 1'b1 || o_req_cycles !== 0 || o_done_cyc !== 1) begin bad++;
            $display("FAIL illegal_ld got=err%b req%0d cyc%0d want=err1 req0 cyc1",
                     o_err, o_req_cycles, o_done_cyc); end
        run_access(1'b1, 3'b101, 32'h0000_0040, 32'h1111_2222, 0, 0, 32'h0);
        total++; if (o_err !== 1'b1 || o_req_cycles !== 0 || o_rd !== exp_rd) begin bad++;
            $display("FAIL illegal_st got=err%b req%0d rd%h want=err1 req0 rd%h",
                     o_err, o_req_cycles, o_rd, exp_rd); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 3'b001, 32'h0000_3002, 32'h0000_BEEF, 0, 0, 32'h0);
        total++; if (o_done_cyc !== 2 || o_be !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF) begin
            bad++;
            $display("FAIL b2b_sh got=cyc%0d be%b %h want=cyc2 be1100 beefbeef",
                     o_done_cyc, o_be, o_wdata); end
        run_access(1'b0, 3'b101, 32'h0000_3002, 32'h0, 0, 0, 32'hBEEF_0000);
        total++; if (o_done_cyc !== 3 || o_rd !== 32'h0000_BEEF || o_err !== 1'b0) begin bad++;
            $display("FAIL b2b_lhu got=cyc%0d %h err%b want=cyc3 0000beef err0",
                     o_done_cyc, o_rd, o_err); end
        exp_rd = 32'h0000_BEEF;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_4008; mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        total++; if (busy !== 1'b1 || rd_data !== exp_rd) begin bad++;
            $display("FAIL resp_pre got=busy%b %h want=busy1 %h", busy, rd_data, exp_rd); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, done, err} !== 3'b0 || rd_data !== 32'h0) begin bad++;
            $display("FAIL resp_rst got=%b %h want=000 0", {busy, done, err}, rd_data); end
        @(negedge clk);
        rst_n = 1'b1; exp_rd = 32'h0;
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
        @(negedge clk);
        start = 1'b0;
        total++; if (mem_req !== 1'b1) begin bad++;
            $display("FAIL req_pre got=%b want=1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({mem_req, mem_we, busy} !== 3'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0)
            begin bad++;
            $display("FAIL req_rst got=%b %h %b want=000 0 0", {mem_req, mem_we, busy},
                     mem_addr, mem_be); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0]  codes [5];
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, rdat;
        int          g, r;
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : codes[$urandom_range(0, 4)];
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            g    = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            r    = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
            predict(st, f3, a, g, r);
            run_access(st, f3, a, wd, g, r, rdat);
            if (e_load_ok) exp_rd = m_load(f3, a, rdat);
            total++; if (o_done_cyc !== e_done || o_done_cnt !== 1) begin bad++;
                $display("FAIL rnd%0d done got=cyc%0d n%0d want=cyc%0d n1",
                         i, o_done_cyc, o_done_cnt, e_done); end
            total++; if (o_err !== e_err) begin bad++;
                $display("FAIL rnd%0d err got=%b want=%b", i, o_err, e_err); end
            total++; if (o_rd !== exp_rd) begin bad++;
                $display("FAIL rnd%0d rd got=%h want=%h", i, o_rd, exp_rd); end
            total++; if (o_busy_cycles !== e_done || o_busy_after !== 1'b0) begin bad++;
                $display("FAIL rnd%0d busy got=%0d after=%b want=%0d after=0",
                         i, o_busy_cycles, o_busy_after, e_done); end
            total++; if (o_req_cycles !== e_req || o_req_unstable !== 1'b0) begin bad++;
                $display("FAIL rnd%0d req got=%0d unstable=%b want=%0d",
                         i, o_req_cycles, o_req_unstable, e_req); end
            if (e_req > 0) begin
                total++; if (o_addr !== {a[31:2], 2'b00} || o_we !== st) begin bad++;
                    $display("FAIL rnd%0d addr got=%h we=%b want=%h we=%b",
                             i, o_addr, o_we, {a[31:2], 2'b00}, st); end
                total++; if (o_be !== m_be(f3, a)) begin bad++;
                    $display("FAIL rnd%0d be got=%b want=%b", i, o_be, m_be(f3, a)); end
                if (st) begin
                    total++; if (o_wdata !== m_wdata(f3, wd)) begin bad++;
                        $display("FAIL rnd%0d wdata got=%h want=%h", i, o_wdata, m_wdata(f3, wd));
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; exp_rd = 32'h0;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_store();
        test_load();
        test_delayed();
        test_timeout();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
